uart_cmd_parser: RTL and testbench

//  Consumes the byte stream of the UART receiver (toggle-per-byte handshake) and assembles

---
 rtl/uart_cmd_pkg.sv | 30 +++
 rtl/uart_byte_event.sv | 43 ++++
 rtl/uart_cmd_parser.sv | 209 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART object-update command parser.
// Checksum byte support is selected with UART_CMD_CHECKSUM_EN.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ID     = 3'd1;
  localparam logic [2:0] ST_XH     = 3'd2;
  localparam logic [2:0] ST_XL     = 3'd3;
  localparam logic [2:0] ST_YH     = 3'd4;
  localparam logic [2:0] ST_YL     = 3'd5;
  localparam logic [2:0] ST_CSUM   = 3'd6;
  localparam logic [2:0] ST_COMMIT = 3'd7;

  localparam int unsigned PKT_LEN_BASE = 6;
  localparam int unsigned PKT_LEN_CSUM = 7;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int unsigned PKT_LEN = PKT_LEN_CSUM;
`else
  localparam int unsigned PKT_LEN = PKT_LEN_BASE;
`endif

  function automatic logic [7:0] pkt_csum(input logic [7:0] id, input logic [7:0] xh,
                                          input logic [7:0] xl, input logic [7:0] yh,
                                          input logic [7:0] yl);
    return id ^ xh ^ xl ^ yh ^ yl;
  endfunction

endpackage

// File: rtl/uart_byte_event.sv
// Turns the receiver's toggle-per-byte handshake into a registered one-cycle
// event, capturing the byte and its error flag alongside it.
module uart_byte_event (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] dt_i,
  input  logic       dtavail_i,
  input  logic       bad_i,
  output logic       ev_o,
  output logic [7:0] byte_o,
  output logic       bad_o
);

  logic       tog_q;
  logic       ev_q;
  logic [7:0] byte_q;
  logic       bad_q;
  logic       ev_c;

  assign ev_c = dtavail_i ^ tog_q;

  // Tracking dtavail during reset keeps release from looking like a new byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tog_q  <= dtavail_i;
      ev_q   <= 1'b0;
      byte_q <= 8'd0;
      bad_q  <= 1'b0;
    end else begin
      tog_q <= dtavail_i;
      ev_q  <= ev_c;
      if (ev_c) begin
        byte_q <= dt_i;
        bad_q  <= bad_i;
      end
    end
  end

  assign ev_o   = ev_q;
  assign byte_o = byte_q;
  assign bad_o  = bad_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Object-update packet parser: sync, field/range/timeout validation, write strobe
// and saturating reject counter. Define UART_CMD_CHECKSUM_EN for the 7-byte format.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ID_W        = 6,
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [7:0]      dt,
  input  logic            dtavail,
  input  logic            bad,
  output logic [ID_W-1:0] obj_id,
  output logic [9:0]      obj_x,
  output logic [9:0]      obj_y,
  output logic            obj_we,
  output logic            pkt_err,
  output logic [7:0]      err_count
);

  localparam int unsigned CTR_W = $clog2(TIMEOUT_CYC);

  logic            ev;
  logic [7:0]      ev_byte;
  logic            ev_bad;

  logic [2:0]      state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [1:0]      xh_q, xh_d;
  logic [7:0]      xl_q, xl_d;
  logic [1:0]      yh_q, yh_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]      yl_q, yl_d;
`endif
  logic [ID_W-1:0] obj_id_q, obj_id_d;
  logic [9:0]      obj_x_q, obj_x_d;
  logic [9:0]      obj_y_q, obj_y_d;
  logic            obj_we_q, obj_we_d;
  logic            pkt_err_q, pkt_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [9:0]      x_c, y_c;
  logic            range_bad_c;
  logic            reject_c, commit_c;

  uart_byte_event u_byte_event (
    .clk_i     (CLOCK),
    .rst_i     (RESET),
    .dt_i      (dt),
    .dtavail_i (dtavail),
    .bad_i     (bad),
    .ev_o      (ev),
    .byte_o    (ev_byte),
    .bad_o     (ev_bad)
  );

  assign x_c = {xh_q, xl_q};
`ifdef UART_CMD_CHECKSUM_EN
  assign y_c = {yh_q, yl_q};
`else
  assign y_c = {yh_q, ev_byte};
`endif
  assign range_bad_c = (32'(x_c) >= H_RES) || (32'(y_c) >= V_RES);

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q + CTR_W'(1);
    id_d      = id_q;
    xh_d      = xh_q;
    xl_d      = xl_q;
    yh_d      = yh_q;
`ifdef UART_CMD_CHECKSUM_EN
    yl_d      = yl_q;
`endif
    obj_id_d  = obj_id_q;
    obj_x_d   = obj_x_q;
    obj_y_d   = obj_y_q;
    obj_we_d  = 1'b0;
    pkt_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    reject_c  = 1'b0;
    commit_c  = 1'b0;

    case (state_q)
      // COMMIT lasts one cycle and must still see a sync byte arriving in it.
      ST_IDLE, ST_COMMIT: begin
        ctr_d = '0;
        if (ev && !ev_bad && ev_byte == SYNC_BYTE) state_d = ST_ID;
        else                                       state_d = ST_IDLE;
      end
      ST_ID: if (ev) begin
        if (ev_bad || (ev_byte >> ID_W) != 8'd0) reject_c = 1'b1;
        else begin
          id_d    = ev_byte[ID_W-1:0];
          state_d = ST_XH;
        end
      end
      ST_XH: if (ev) begin
        if (ev_bad || ev_byte[7:2] != 6'd0) reject_c = 1'b1;
        else begin
          xh_d    = ev_byte[1:0];
          state_d = ST_XL;
        end
      end
      ST_XL: if (ev) begin
        if (ev_bad) reject_c = 1'b1;
        else begin
          xl_d    = ev_byte;
          state_d = ST_YH;
        end
      end
      ST_YH: if (ev) begin
        if (ev_bad || ev_byte[7:2] != 6'd0) reject_c = 1'b1;
        else begin
          yh_d    = ev_byte[1:0];
          state_d = ST_YL;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      ST_YL: if (ev) begin
        if (ev_bad) reject_c = 1'b1;
        else begin
          yl_d    = ev_byte;
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: if (ev) begin
        if (ev_bad || range_bad_c ||
            ev_byte != pkt_csum(8'(id_q), 8'(xh_q), xl_q, 8'(yh_q), yl_q)) reject_c = 1'b1;
        else commit_c = 1'b1;
      end
`else
      ST_YL: if (ev) begin
        if (ev_bad || range_bad_c) reject_c = 1'b1;
        else                       commit_c = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (ev) ctr_d = '0;

    // A byte arriving in the expiry cycle takes precedence over the timeout.
    if (!ev && state_q != ST_IDLE && state_q != ST_COMMIT &&
        ctr_q == CTR_W'(TIMEOUT_CYC - 1)) reject_c = 1'b1;

    if (commit_c) begin
      obj_id_d = id_q;
      obj_x_d  = x_c;
      obj_y_d  = y_c;
      obj_we_d = 1'b1;
      state_d  = ST_COMMIT;
    end

    if (reject_c) begin
      state_d   = ST_IDLE;
      pkt_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      ctr_q     <= '0;
      id_q      <= '0;
      xh_q      <= 2'd0;
      xl_q      <= 8'd0;
      yh_q      <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
      yl_q      <= 8'd0;
`endif
      obj_id_q  <= '0;
      obj_x_q   <= 10'd0;
      obj_y_q   <= 10'd0;
      obj_we_q  <= 1'b0;
      pkt_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      id_q      <= id_d;
      xh_q      <= xh_d;
      xl_q      <= xl_d;
      yh_q      <= yh_d;
`ifdef UART_CMD_CHECKSUM_EN
      yl_q      <= yl_d;
`endif
      obj_id_q  <= obj_id_d;
      obj_x_q   <= obj_x_d;
      obj_y_q   <= obj_y_d;
      obj_we_q  <= obj_we_d;
      pkt_err_q <= pkt_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign obj_id    = obj_id_q;
  assign obj_x     = obj_x_q;
  assign obj_y     = obj_y_q;
  assign obj_we    = obj_we_q;
  assign pkt_err   = pkt_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (both UART_CMD_CHECKSUM_EN builds).
module tb_uart_cmd_parser;

  localparam int unsigned TO = 40;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] dt = 8'd0;
  logic       dtavail = 1'b0;
  logic       bad = 1'b0;
  logic [5:0] obj_id;
  logic [9:0] obj_x;
  logic [9:0] obj_y;
  logic       obj_we;
  logic       pkt_err;
  logic [7:0] err_count;

  int total = 0;
  int bad_n = 0;
  int we_cnt = 0;
  int perr_cnt = 0;
  int exp_we = 0;
  int exp_perr = 0;

  uart_cmd_parser #(
    .ID_W(6), .H_RES(640), .V_RES(480), .TIMEOUT_CYC(TO)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .dt(dt), .dtavail(dtavail), .bad(bad),
    .obj_id(obj_id), .obj_x(obj_x), .obj_y(obj_y), .obj_we(obj_we),
    .pkt_err(pkt_err), .err_count(err_count)
  );

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (obj_we) we_cnt++;
    if (pkt_err) perr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bd);
    @(negedge CLOCK);
    dt = b;
    bad = bd;
    dtavail = ~dtavail;
  endtask

  task automatic send_pkt(input logic [7:0] id, input logic [7:0] xh, input logic [7:0] xl,
                          input logic [7:0] yh, input logic [7:0] yl, input logic [7:0] cs);
    send_byte(8'hAA, 1'b0); idle(2);
    send_byte(id, 1'b0);    idle(2);
    send_byte(xh, 1'b0);    idle(2);
    send_byte(xl, 1'b0);    idle(2);
    send_byte(yh, 1'b0);    idle(2);
    send_byte(yl, 1'b0);    idle(2);
    if (CSUM_EN) begin
      send_byte(cs, 1'b0);  idle(2);
    end
    idle(3);
  endtask

  task automatic chk_obj(input string tag, input int id, input int x, input int y);
    chk({tag, "_id"}, 32'(obj_id), 32'(id));
    chk({tag, "_x"}, 32'(obj_x), 32'(x));
    chk({tag, "_y"}, 32'(obj_y), 32'(y));
  endtask

  task automatic chk_cnts(input string tag, input int errs);
    chk({tag, "_we_cnt"}, 32'(we_cnt), 32'(exp_we));
    chk({tag, "_perr_cnt"}, 32'(perr_cnt), 32'(exp_perr));
    chk({tag, "_err_count"}, 32'(err_count), 32'(errs));
  endtask

  initial begin
    logic [7:0] last;
    // reset state
    idle(4);
    RESET = 1'b0;
    idle(3);
    chk_obj("reset", 0, 0, 0);
    chk("reset_we", 32'(obj_we), 32'd0);
    chk("reset_perr", 32'(pkt_err), 32'd0);
    chk_cnts("reset", 0);

    // test 1: good packet with exact strobe latency
    send_byte(8'hAA, 1'b0); idle(2);
    send_byte(8'h05, 1'b0); idle(2);
    send_byte(8'h01, 1'b0); idle(2);
    send_byte(8'h2C, 1'b0); idle(2);
    send_byte(8'h00, 1'b0); idle(2);
    last = 8'hF0;
    if (CSUM_EN) begin
      send_byte(8'hF0, 1'b0); idle(2);
      last = 8'hD8;
    end
    send_byte(last, 1'b0);
    idle(1);
    chk("t1_we_lat1", 32'(obj_we), 32'd0);
    chk_obj("t1_hold", 0, 0, 0);
    idle(1);
    chk("t1_we_lat2", 32'(obj_we), 32'd1);
    chk_obj("t1", 5, 300, 240);
    idle(1);
    chk("t1_we_lat3", 32'(obj_we), 32'd0);
    idle(3);
    exp_we = 1;
    chk_cnts("t1", 0);

    // test 2: noise then packet; 0xAA as plain data mid-packet; max id
    send_byte(8'h13, 1'b0); idle(2);
    send_byte(8'h7F, 1'b0); idle(2);
    send_byte(8'hAA, 1'b1); idle(2);
    send_byte(8'h05, 1'b0); idle(3);
    chk_cnts("t2_noise", 0);
    send_pkt(8'h05, 8'h01, 8'h2C, 8'h00, 8'hF0, 8'hD8);
    exp_we = 2;
    chk_cnts("t2_pkt", 0);
    chk_obj("t2_pkt", 5, 300, 240);
    send_pkt(8'h3F, 8'h00, 8'hAA, 8'h01, 8'h00, 8'h94);
    exp_we = 3;
    chk_cnts("t2_aa_data", 0);
    chk_obj("t2_aa_data", 63, 170, 256);

    // test 3: range and field boundaries
    send_pkt(8'h05, 8'h01, 8'h80, 8'h01, 8'hE0, 8'h65);
    exp_perr = 1;
    chk_cnts("t3_y480", 1);
    chk_obj("t3_y480", 63, 170, 256);
    send_pkt(8'h01, 8'h02, 8'h7F, 8'h01, 8'hDF, 8'hA2);
    exp_we = 4;
    chk_cnts("t3_max_ok", 1);
    chk_obj("t3_max_ok", 1, 639, 479);
    send_pkt(8'h01, 8'h02, 8'h80, 8'h00, 8'h00, 8'h83);
    exp_perr = 2;
    chk_cnts("t3_x640", 2);
    send_pkt(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_perr = 3;
    chk_cnts("t3_id_range", 3);
    send_pkt(8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_perr = 4;
    chk_cnts("t3_xhi_range", 4);
    chk_obj("t3_after_rejects", 1, 639, 479);

    // test 4: inter-byte timeout, then recovery
    send_byte(8'hAA, 1'b0); idle(2);
    send_byte(8'h05, 1'b0); idle(TO - 5);
    chk_cnts("t4_before_to", 4);
    idle(10);
    exp_perr = 5;
    chk_cnts("t4_timeout", 5);
    send_pkt(8'h05, 8'h01, 8'h2C, 8'h00, 8'hF0, 8'hD8);
    exp_we = 5;
    chk_cnts("t4_recover", 5);
    chk_obj("t4_recover", 5, 300, 240);

    // test 4b: byte arriving exactly in the expiry cycle is accepted
    send_byte(8'hAA, 1'b0); idle(2);
    send_byte(8'h07, 1'b0); idle(TO - 1);
    send_byte(8'h00, 1'b0); idle(2);
    send_byte(8'h10, 1'b0); idle(2);
    send_byte(8'h00, 1'b0); idle(2);
    send_byte(8'h20, 1'b0); idle(2);
    if (CSUM_EN) begin
      send_byte(8'h37, 1'b0); idle(2);
    end
    idle(3);
    exp_we = 6;
    chk_cnts("t4_expiry_win", 5);
    chk_obj("t4_expiry_win", 7, 16, 32);

    // test 5: receiver error flag after sync, then saturation
    send_byte(8'hAA, 1'b0); idle(2);
    send_byte(8'h05, 1'b0); idle(2);
    send_byte(8'h01, 1'b1); idle(3);
    exp_perr = 6;
    chk_cnts("t5_bad_b3", 6);
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hAA, 1'b0); idle(1);
      send_byte(8'h05, 1'b1); idle(1);
    end
    idle(3);
    exp_perr = 266;
    chk_cnts("t5_saturate", 255);
    send_byte(8'hAA, 1'b0); idle(1);
    send_byte(8'h05, 1'b1); idle(3);
    exp_perr = 267;
    chk_cnts("t5_sat_hold", 255);
    chk_obj("t5_obj_hold", 7, 16, 32);

    // test 6: wrong checksum (checksum build only)
    if (CSUM_EN) begin
      send_pkt(8'h05, 8'h01, 8'h2C, 8'h00, 8'hF0, 8'hDB);
      exp_perr = 268;
      chk_cnts("t6_bad_csum", 255);
    end

    // reset mid-packet with dtavail high: no event or error after release
    send_byte(8'hAA, 1'b0); idle(2);
    send_byte(8'h05, 1'b0); idle(1);
    RESET = 1'b1;
    dtavail = 1'b1;
    dt = 8'hAA;
    idle(3);
    RESET = 1'b0;
    idle(TO + 5);
    chk_cnts("t6_reset", 0);
    chk_obj("t6_reset", 0, 0, 0);
    send_pkt(8'h02, 8'h00, 8'h64, 8'h00, 8'h32, 8'h54);
    exp_we = exp_we + 1;
    chk_cnts("t6_post_reset", 0);
    chk_obj("t6_post_reset", 2, 100, 50);

    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

endmodule
